// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// stage (IF port) and the load/store path (D port). One transaction is in
// flight at a time. The winner's fields are registered onto the mem_* port
// and held until mem_ack. The read data is then registered into the winning
// port's rdata register, and that port gets a one-cycle ack.
//
// Data has priority over fetch. A data streak counter bounds how many
// consecutive D grants may be issued while a fetch is waiting, so fetch
// cannot starve.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req, if_addr                 fetch request (held until if_ack)
//   if_ack, if_rdata                fetch completion pulse, registered data
//   d_req, d_we, d_addr,
//   d_wdata, d_be                   load/store request (held until d_ack)
//   d_ack, d_rdata                  data completion pulse, registered data
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be               memory request, held until mem_ack
//   mem_ack, mem_rdata              memory completion, rdata valid with ack
//   busy                            high whenever a transfer is in progress
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_F,
        BUSY_D,
        RESP
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                grant_d;

    // Data wins unless a fetch is waiting and data has used up its streak.
    assign grant_d = d_req && (!if_req || (streak != STREAK_MAX));

    assign busy = (state != IDLE);

    // NOTE: all state and registered outputs are assigned with <= so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            // NOTE: acks default low here so they are single-cycle pulses
            // without a separate clear path in every state.
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        state     <= BUSY_D;
                        // Streak only counts D grants that made a fetch wait.
                        if (if_req) begin
                            if (streak != STREAK_MAX) begin
                                streak <= streak + 1'b1;
                            end
                        end else begin
                            streak <= '0;
                        end
                    end else if (if_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= {BE_W{1'b1}};
                        state     <= BUSY_F;
                        streak    <= '0;
                    end else begin
                        streak <= '0;
                    end
                end

                BUSY_F: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        state    <= RESP;
                    end
                end

                BUSY_D: begin
                    // Stores capture mem_rdata as well; the data port sees
                    // whatever the memory returned with its ack.
                    if (mem_ack) begin
                        d_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        d_ack   <= 1'b1;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    // Ack is visible this cycle; a held request is sampled
                    // again in the following IDLE cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. Each expected memory transaction is pushed to a
// scoreboard queue when its request is driven. It is popped and compared when
// the DUT raises mem_req. The bench keeps its own copies of the expected
// if_rdata / d_rdata values.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef struct {
        bit                is_d;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    txn_t              sb[$];
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_d_rdata;
    int                vectors     = 0;
    int                miscompares = 0;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_D_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_f(input logic [ADDR_W-1:0] addr);
        txn_t t;
        t.is_d  = 1'b0;
        t.we    = 1'b0;
        t.addr  = addr;
        t.wdata = '0;
        t.be    = '1;
        sb.push_back(t);
    endtask

    task automatic push_d(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
        txn_t t;
        t.is_d  = 1'b1;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.be    = be;
        sb.push_back(t);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!mem_req && n < budget) begin
            step();
            n++;
        end
        check("mem_req_arrival", mem_req, 1);
    endtask

    // Pop the next expected transaction and compare its fields with the
    // mem_* port.
    task automatic check_fields(output txn_t e);
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL sb_underflow: observed %0d entries expected >0", sb.size());
        end
        if (sb.size() > 0) e = sb.pop_front();
        check("mem_req",   mem_req,   1);
        check("mem_we",    mem_we,    e.we);
        check("mem_addr",  mem_addr,  e.addr);
        check("mem_wdata", mem_wdata, e.wdata);
        check("mem_be",    mem_be,    e.be);
    endtask

    // Called on the first cycle mem_req should be high. Holds off mem_ack for
    // 'waits' cycles, then acks with 'rd'. Returns on the RESP-cycle negedge,
    // after the ack pulse has been checked.
    task automatic serve(input int waits, input logic [DATA_W-1:0] rd);
        txn_t e;
        check_fields(e);
        for (int i = 0; i < waits; i++) begin
            step();
            check("mem_req_hold",  mem_req,  1);
            check("mem_addr_hold", mem_addr, e.addr);
            check("mem_be_hold",   mem_be,   e.be);
            check("early_ack",     {if_ack, d_ack}, 2'b00);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAAD_F00D;
        if (e.is_d) exp_d_rdata = rd;
        else        exp_if_rdata = rd;
        check("if_ack",      if_ack,   !e.is_d);
        check("d_ack",       d_ack,    e.is_d);
        check("if_rdata",    if_rdata, exp_if_rdata);
        check("d_rdata",     d_rdata,  exp_d_rdata);
        check("mem_req_off", mem_req,  0);
    endtask

    task automatic finish_resp();
        step();
        check("ack_single", {if_ack, d_ack}, 2'b00);
        check("busy_idle",  busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;

        // Reset state
        repeat (2) step();
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be",    mem_be,    0);
        check("rst_acks",      {if_ack, d_ack}, 2'b00);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_d_rdata",   d_rdata,   0);
        check("rst_busy",      busy,      0);
        rst_n = 1'b1;
        step();
        check("idle_no_req", mem_req, 0);

        // Single fetch, immediate ack: if_ack two cycles after the request
        if_req  = 1'b1;
        if_addr = 32'h100;
        push_f(32'h100);
        step();
        check("busy_f", busy, 1);
        serve(0, 32'h0050_0093);
        if_req = 1'b0;
        finish_resp();

        // Store with three wait cycles
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2004;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'b0011;
        push_d(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011);
        step();
        serve(3, 32'h1234_5678);
        d_req = 1'b0;
        finish_resp();

        // Spurious ack in IDLE
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        repeat (2) begin
            step();
            check("spur_idle_req",  mem_req,  0);
            check("spur_idle_ack",  {if_ack, d_ack}, 2'b00);
            check("spur_idle_ifrd", if_rdata, exp_if_rdata);
            check("spur_idle_drd",  d_rdata,  exp_d_rdata);
        end
        mem_ack = 1'b0;

        // Back-to-back fetch with the address changed during RESP.
        // A spurious ack is also driven during RESP and must be ignored.
        if_req  = 1'b1;
        if_addr = 32'h100;
        push_f(32'h100);
        step();
        serve(0, 32'h0000_0013);
        if_addr   = 32'h104;
        push_f(32'h104);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        check("b2b_gap_req",  mem_req,  0);
        check("spur_resp_ack", {if_ack, d_ack}, 2'b00);
        check("spur_resp_rd", if_rdata, exp_if_rdata);
        step();
        serve(0, 32'h0041_0113);
        if_req = 1'b0;
        finish_resp();

        // Contention with immediate ack: D,D,D,D,F repeating
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h3000;
        d_wdata = 32'h0;
        d_be    = 4'b1111;
        if_req  = 1'b1;
        if_addr = 32'h200;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_d(1'b0, 32'h3000, 32'h0, 4'b1111);
            push_f(32'h200);
        end
        for (int i = 0; i < 10; i++) begin
            wait_req(4);
            serve(0, 32'hC000_0000 + 32'(i));
        end

        // Reset in BUSY_D after two D grants; the streak must restart at zero
        for (int i = 0; i < 2; i++) begin
            push_d(1'b0, 32'h3000, 32'h0, 4'b1111);
            wait_req(4);
            serve(0, 32'hD000_0000 + 32'(i));
        end
        push_d(1'b0, 32'h3000, 32'h0, 4'b1111);
        wait_req(4);
        begin
            txn_t e;
            check_fields(e);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_req",  mem_req, 0);
        check("rst_mid_busy", busy,    0);
        check("rst_mid_ack",  {if_ack, d_ack}, 2'b00);
        sb.delete();
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        mem_ack      = 1'b1;
        step();
        mem_ack = 1'b0;
        check("rst_hold_ack", {if_ack, d_ack}, 2'b00);
        check("rst_hold_drd", d_rdata, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) push_d(1'b0, 32'h3000, 32'h0, 4'b1111);
        push_f(32'h200);
        for (int i = 0; i < 5; i++) begin
            wait_req(4);
            serve(0, 32'hE000_0000 + 32'(i));
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        finish_resp();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
